sh_conv_ctrl: RTL and testbench

- Digital sequencer that drives the ena/hold pins of the sample_and_hold analog macro.
- Handshakes with the downstream ADC that digitises the held voltage.
- Sequence: power-up/warm-up, then a programmable track window, then hold while the ADC converts, then release and count the sample.
- Sits in the 1.8V digital domain between the user register bank and the S&H/ADC pair.

---
 rtl/sh_conv_ctrl.sv | 116 +++++++++++
 tb/tb_sh_conv_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_conv_ctrl.sv
// sh_conv_ctrl: sequences the sample-and-hold ena/hold pins and handshakes with the ADC.
// All outputs are registered from the next state, so no input reaches an output combinationally.
module sh_conv_ctrl #(
    parameter int CW      = 8,
    parameter int SCW     = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           start,
    input  logic           cont,
    input  logic [CW-1:0]  warmup_cyc,
    input  logic [CW-1:0]  track_cyc,
    input  logic           adc_done,
    output logic           sh_ena,
    output logic           sh_hold,
    output logic           adc_start,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [SCW-1:0] sample_cnt
);
    typedef enum logic [2:0] {OFF, WARMUP, READY, TRACK, HOLD} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [SCW-1:0] sample_cnt_q, sample_cnt_d;
    logic           sh_ena_q, sh_ena_d, sh_hold_q, sh_hold_d, adc_start_q, adc_start_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic           conv_ok, conv_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            tmo_q        <= '0;
            sample_cnt_q <= '0;
            sh_ena_q     <= 1'b0;
            sh_hold_q    <= 1'b0;
            adc_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            sample_cnt_q <= sample_cnt_d;
            sh_ena_q     <= sh_ena_d;
            sh_hold_q    <= sh_hold_d;
            adc_start_q  <= adc_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // adc_done in the adc_start cycle (tmo_q == 0) is ignored; adc_done beats the timeout
    assign conv_ok  = en && state_q == HOLD && adc_done && tmo_q != 16'd0;
    assign conv_tmo = en && state_q == HOLD && !conv_ok && tmo_q == 16'(TIMEOUT - 1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = '0;
        sample_cnt_d = conv_ok ? sample_cnt_q + 1'b1 : sample_cnt_q;
        if (!en) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = WARMUP;
                    cnt_d   = warmup_cyc;
                end
                WARMUP: begin
                    state_d = cnt_q == '0 ? READY : WARMUP;
                    cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                end
                READY: begin
                    state_d = start || cont ? TRACK : READY;
                    cnt_d   = start || cont ? track_cyc : cnt_q;
                end
                TRACK: begin
                    state_d = cnt_q == '0 ? HOLD : TRACK;
                    cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                end
                HOLD: begin
                    state_d = conv_ok ? (cont ? TRACK : READY) : conv_tmo ? READY : HOLD;
                    cnt_d   = conv_ok && cont ? track_cyc : cnt_q;
                    tmo_d   = conv_ok || conv_tmo ? 16'd0 : tmo_q + 16'd1;
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_comb begin
        sh_ena_d    = state_d != OFF;
        sh_hold_d   = state_d == HOLD;
        adc_start_d = state_d == HOLD && state_q != HOLD;
        busy_d      = state_d == TRACK || state_d == HOLD;
        done_d      = conv_ok;
        err_d       = conv_tmo;
    end

    assign sh_ena     = sh_ena_q;
    assign sh_hold    = sh_hold_q;
    assign adc_start  = adc_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_sh_conv_ctrl.sv
// tb_sh_conv_ctrl: scenario tasks plus an ADC responder that queues the expected done/err outcome.
module tb_sh_conv_ctrl;
    localparam int CW = 8, SCW = 4, TIMEOUT = 8;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, cont = 1'b0;
    logic [CW-1:0] warmup_cyc = '0, track_cyc = '0;
    logic adc_done_r = 1'b0, adc_done_t = 1'b0, adc_done;
    logic sh_ena, sh_hold, adc_start, busy, done, err;
    logic [SCW-1:0] sample_cnt;
    logic [5:0] outs;

    int checks = 0, errors = 0, cyc = 0, adc_delay = -1, d;
    logic [SCW-1:0] exp_cnt = '0;
    typedef struct { bit is_err; logic [SCW-1:0] cnt; int at; } exp_t;
    exp_t sb[$];
    exp_t e_new, e_got;

    assign adc_done = adc_done_r | adc_done_t;
    assign outs = {sh_ena, sh_hold, adc_start, busy, done, err};

    sh_conv_ctrl #(.CW(CW), .SCW(SCW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont),
        .warmup_cyc(warmup_cyc), .track_cyc(track_cyc), .adc_done(adc_done),
        .sh_ena(sh_ena), .sh_hold(sh_hold), .adc_start(adc_start), .busy(busy),
        .done(done), .err(err), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: answers each adc_start after adc_delay cycles and queues the outcome it implies
    initial forever begin
        @(negedge clk);
        if (!rst_n) exp_cnt = '0;
        else if (adc_start === 1'b1) begin
            d = adc_delay;
            e_new.is_err = !(d >= 1 && d < TIMEOUT);
            if (!e_new.is_err) exp_cnt = exp_cnt + 1'b1;
            e_new.cnt = exp_cnt;
            e_new.at  = e_new.is_err ? cyc + TIMEOUT : cyc + d + 1;
            sb.push_back(e_new);
            if (d >= 0 && d <= 20) begin
                repeat (d) @(negedge clk);
                adc_done_r = 1'b1;
                @(negedge clk);
                adc_done_r = 1'b0;
            end
        end
    end

    always @(negedge clk) if (rst_n && (done || err)) begin
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: done=%b err=%b cnt=%0d cyc=%0d, required no event", done, err, sample_cnt, cyc);
        end else begin
            e_got = sb.pop_front();
            if (err !== e_got.is_err || done !== !e_got.is_err || sample_cnt !== e_got.cnt || cyc != e_got.at) begin
                errors++;
                $display("FAIL sb_event: done=%b err=%b cnt=%0d cyc=%0d, required err=%b cnt=%0d cyc=%0d",
                         done, err, sample_cnt, cyc, e_got.is_err, e_got.cnt, e_got.at);
            end
        end
    end

    task automatic wait_event(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || err) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: no done/err in %0d cycles, required one", name, budget);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (outs !== 6'b0 || sample_cnt !== '0) begin
            errors++;
            $display("FAIL reset: outs=%b cnt=%0d, required 000000 0", outs, sample_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_warmup();
        en = 1'b1;
        warmup_cyc = 8'd3;
        track_cyc = 8'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 6'b100000) begin
                errors++;
                $display("FAIL warmup_%0d: outs=%b, required 100000", i, outs);
            end
            if (i == 3) start = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (outs !== 6'b100000) begin
            errors++;
            $display("FAIL warmup_ready: outs=%b, required 100000", outs);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (outs !== 6'b100100) begin
            errors++;
            $display("FAIL warmup_start: outs=%b, required 100100", outs);
        end
    endtask

    task automatic test_single();
        adc_delay = 5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 6'b100100) begin
                errors++;
                $display("FAIL single_track_%0d: outs=%b, required 100100", i, outs);
            end
        end
        @(negedge clk);
        checks++;
        if (outs !== 6'b111100) begin
            errors++;
            $display("FAIL single_hold0: outs=%b, required 111100", outs);
        end
        @(negedge clk);
        checks++;
        if (outs !== 6'b110100) begin
            errors++;
            $display("FAIL single_hold1: outs=%b, required 110100", outs);
        end
        wait_event(20, "single");
        checks++;
        if (outs !== 6'b100010 || sample_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_done: outs=%b cnt=%0d, required 100010 1", outs, sample_cnt);
        end
        @(negedge clk);
        checks++;
        if (outs !== 6'b100000) begin
            errors++;
            $display("FAIL single_ready: outs=%b, required 100000", outs);
        end
    endtask

    task automatic test_cont();
        cont = 1'b1;
        track_cyc = 8'd0;
        adc_delay = 2;
        for (int k = 1; k <= 10; k++) begin
            wait_event(20, "cont");
            checks++;
            if (outs !== 6'b100110 || sample_cnt !== 4'(1 + k)) begin
                errors++;
                $display("FAIL cont_done_%0d: outs=%b cnt=%0d, required 100110 %0d", k, outs, sample_cnt, 1 + k);
            end
            @(negedge clk);
            checks++;
            if (outs !== 6'b111100) begin
                errors++;
                $display("FAIL cont_hold_%0d: outs=%b, required 111100", k, outs);
            end
        end
        cont = 1'b0;
        wait_event(20, "cont_stop");
        checks++;
        if (outs !== 6'b100010 || sample_cnt !== 4'd12) begin
            errors++;
            $display("FAIL cont_stop: outs=%b cnt=%0d, required 100010 12", outs, sample_cnt);
        end
        @(negedge clk);
        checks++;
        if (outs !== 6'b100000) begin
            errors++;
            $display("FAIL cont_ready: outs=%b, required 100000", outs);
        end
    endtask

    task automatic test_timeout();
        int dl[4] = '{-1, 7, 8, 0};
        logic [5:0] want[4] = '{6'b100001, 6'b100010, 6'b100001, 6'b100001};
        logic [SCW-1:0] wcnt[4] = '{4'd12, 4'd13, 4'd13, 4'd13};
        track_cyc = 8'd1;
        for (int i = 0; i < 4; i++) begin
            adc_delay = dl[i];
            pulse_start();
            wait_event(30, "timeout");
            checks++;
            if (outs !== want[i] || sample_cnt !== wcnt[i]) begin
                errors++;
                $display("FAIL timeout_d%0d: outs=%b cnt=%0d, required %b %0d", dl[i], outs, sample_cnt, want[i], wcnt[i]);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (outs !== 6'b100000 || sample_cnt !== wcnt[i]) begin
                errors++;
                $display("FAIL timeout_after_d%0d: outs=%b cnt=%0d, required 100000 %0d", dl[i], outs, sample_cnt, wcnt[i]);
            end
        end
    endtask

    task automatic test_en_drop();
        adc_delay = -1;
        track_cyc = 8'd5;
        pulse_start();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 6'b0 || sample_cnt !== 4'd13) begin
            errors++;
            $display("FAIL drop_track: outs=%b cnt=%0d, required 000000 13", outs, sample_cnt);
        end
        en = 1'b1;
        warmup_cyc = 8'd0;
        track_cyc = 8'd0;
        @(negedge clk);
        @(negedge clk);
        pulse_start();
        @(negedge clk);
        checks++;
        if (outs !== 6'b111100) begin
            errors++;
            $display("FAIL drop_rewarm_hold: outs=%b, required 111100", outs);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 6'b0 || sample_cnt !== 4'd13) begin
            errors++;
            $display("FAIL drop_hold: outs=%b cnt=%0d, required 000000 13", outs, sample_cnt);
        end
        sb.delete();
        repeat (10) @(negedge clk);
        adc_done_t = 1'b1;
        @(negedge clk);
        adc_done_t = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 6'b0 || sample_cnt !== 4'd13) begin
            errors++;
            $display("FAIL done_in_off: outs=%b cnt=%0d, required 000000 13", outs, sample_cnt);
        end
        en = 1'b1;
        repeat (2) @(negedge clk);
        adc_done_t = 1'b1;
        @(negedge clk);
        adc_done_t = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 6'b100000 || sample_cnt !== 4'd13) begin
            errors++;
            $display("FAIL done_in_ready: outs=%b cnt=%0d, required 100000 13", outs, sample_cnt);
        end
    endtask

    task automatic test_wrap();
        bit saw_zero = 1'b0;
        cont = 1'b1;
        adc_delay = 2;
        for (int k = 0; k < 17; k++) begin
            wait_event(20, "wrap");
            if (sample_cnt === '0) saw_zero = 1'b1;
        end
        cont = 1'b0;
        wait_event(20, "wrap_stop");
        checks++;
        if (!saw_zero || sample_cnt !== 4'd15) begin
            errors++;
            $display("FAIL wrap: saw_zero=%b cnt=%0d, required 1 15", saw_zero, sample_cnt);
        end
    endtask

    task automatic test_async_reset();
        adc_delay = -1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 5 && adc_start !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (outs !== 6'b110100) begin
            errors++;
            $display("FAIL arst_pre: outs=%b, required 110100", outs);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b0 || sample_cnt !== '0) begin
            errors++;
            $display("FAIL arst: outs=%b cnt=%0d, required 000000 0", outs, sample_cnt);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_single();
        test_cont();
        test_timeout();
        test_en_drop();
        test_wrap();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end
endmodule
